data_fifo_arbiter: RTL and testbench
====================================

DATA_FIFO_ARBITER -- requirements
Module: data_fifo_arbiter

Interface
REQ-001 SHALL have parameter FIFO_data_size, default 32: word width.
REQ-002 SHALL have parameter FIFO_depth, default 8: word count, power of two.
REQ-003 SHALL have ports:
- iClock  in  1  single clock, all logic on rising edge.
- iReset  in  1  synchronous, active-high.
- iFlush  in  1  synchronous pointer/count clear.
- iHost_req  in  1  host/DMA requester request.
- iHost_wr  in  1  host op: 1 = push, 0 = pop.
- iHost_data  in  FIFO_data_size  host push word.
- iPhys_req  in  1  data physical-layer requester request.
- iPhys_wr  in  1  phys op: 1 = push, 0 = pop.
- iPhys_data  in  FIFO_data_size  phys push word.
- oHost_grant  out  1  host op performed at previous edge.
- oPhys_grant  out  1  phys op performed at previous edge.
- oData_out  out  FIFO_data_size  popped word.
- oRead_valid  out  1  oData_out valid.
- oFull  out  1  count == FIFO_depth.
- oEmpty  out  1  count == 0.
- oCount  out  log2(FIFO_depth)+1  occupancy.
- oFIFO_ok  out  1  low after any flush-discarded data, until reset.

Function
REQ-004 SHALL perform at most one FIFO operation per edge.
REQ-005 SHALL treat a request as eligible only if push with oFull low, or pop with oEmpty low; ineligible requests SHALL wait, not be granted, and not raise an error.
REQ-006 SHALL arbitrate round-robin with a 1-bit last-granted state: LAST_HOST or LAST_PHYS; if both are eligible, grant the requester not granted last; if one is eligible, grant it; then update the state to the granted requester.
REQ-007 SHALL execute the selected op at edge k; the corresponding grant SHALL be high for exactly cycle k+1; for a pop, oData_out and oRead_valid SHALL be valid in cycle k+1 only.
REQ-008 SHALL treat a request still high at the edge ending a grant cycle as a new request, giving back-to-back streaming at one op per cycle.
REQ-009 SHALL advance write and read pointers modulo FIFO_depth (wrap from 7 to 0).
REQ-010 SHALL update count +1 on push and -1 on pop; count SHALL never exceed FIFO_depth or go below 0.
REQ-011 SHALL decide oFull, oEmpty and eligibility from the registered count at the edge, not from the same-edge update.
REQ-012 iFlush high at an edge SHALL zero the pointers and count, grant nothing, and leave the arbitration state unchanged; it SHALL override all requests.
REQ-013 A flush with count > 0 SHALL clear oFIFO_ok.
REQ-014 oData_out SHALL hold its last value when oRead_valid is low.

Reset
REQ-015 iReset high at an edge SHALL apply:
- pointers and count = 0;
- oEmpty = 1, oFull = 0;
- grants and oRead_valid = 0;
- oData_out = 0, oFIFO_ok = 1;
- state = LAST_PHYS, so the host wins the first tie.
REQ-016 iReset SHALL take priority over iFlush and requests.
REQ-017 Reset mid-stream SHALL discard the stored data, and no grant SHALL appear in the following cycle.

Structure
REQ-018 SHALL take FIFO_data_size, FIFO_depth and the LAST_HOST/LAST_PHYS encodings from a shared package, data_pkg.
REQ-019 SHALL place storage in sub-module data_fifo_mem: single write port, registered read port, no reset on the array.

Verification
REQ-020 After reset, host pushes 0xA5A5_0001..0xA5A5_0008 back-to-back:
- 8 consecutive oHost_grant pulses;
- oCount = 8, oFull = 1;
- a 9th push is held with no grant.
REQ-021 Phys pops 8 words: oData_out = 0xA5A5_0001..0xA5A5_0008 in order, each with oRead_valid; then oEmpty = 1, and a further pop is held.
REQ-022 Count = 4, host push and phys pop both requested continuously: grants alternate host, phys, host, phys...; oCount stays in 4..5.
REQ-023 Count = 0, host push and phys pop requested in the same cycle: only the host is granted; phys is granted next cycle with the host word.
REQ-024 Wrap: push 6, pop 6, push 4 words 0x11..0x44, pop 4: data returns 0x11..0x44 across the 7->0 pointer wrap.
REQ-025 Flush at count = 3 during requests:
- no grant that cycle;
- oCount = 0, oFIFO_ok = 0;
- iReset then restores oFIFO_ok = 1.

Source files
------------

// File: rtl/data_pkg.sv
// Shared sizing and arbitration encodings for the two-requester data FIFO.
package data_pkg;

  localparam int FIFO_DATA_SIZE_DEF = 32;
  localparam int FIFO_DEPTH_DEF     = 8;

  typedef enum logic {
    LAST_HOST = 1'b0,
    LAST_PHYS = 1'b1
  } last_grant_e;

  // A request may only compete when its operation can actually complete.
  function automatic logic req_eligible(input logic req, input logic wr,
                                        input logic full, input logic empty);
    return req && (wr ? !full : !empty);
  endfunction

endpackage

// File: rtl/data_fifo_mem.sv
// FIFO storage: one write port, registered read port; the array itself is never reset.
module data_fifo_mem #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read register holds its value between pops.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_fifo_arbiter.sv
// Single-port FIFO shared by a host and a phys requester, one op per edge,
// round-robin arbitration among requests whose op can complete.
module data_fifo_arbiter
  import data_pkg::*;
#(
  parameter int FIFO_data_size = FIFO_DATA_SIZE_DEF,
  parameter int FIFO_depth     = FIFO_DEPTH_DEF,
  localparam int AW            = $clog2(FIFO_depth),
  localparam int CW            = AW + 1
) (
  input  logic                      iClock,
  input  logic                      iReset,
  input  logic                      iFlush,
  input  logic                      iHost_req,
  input  logic                      iHost_wr,
  input  logic [FIFO_data_size-1:0] iHost_data,
  input  logic                      iPhys_req,
  input  logic                      iPhys_wr,
  input  logic [FIFO_data_size-1:0] iPhys_data,
  output logic                      oHost_grant,
  output logic                      oPhys_grant,
  output logic [FIFO_data_size-1:0] oData_out,
  output logic                      oRead_valid,
  output logic                      oFull,
  output logic                      oEmpty,
  output logic [CW-1:0]             oCount,
  output logic                      oFIFO_ok
);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  last_grant_e   last_q, last_d;
  logic          host_grant_q, phys_grant_q, read_valid_q, fifo_ok_q;

  logic full, empty;
  logic host_elig, phys_elig;
  logic grant_host, grant_phys;
  logic op_wr, push_en, pop_en;
  logic [FIFO_data_size-1:0] wdata;

  // Flags and eligibility come from the registered count only.
  assign full  = (count_q == CW'(FIFO_depth));
  assign empty = (count_q == '0);

  always_comb begin
    host_elig  = req_eligible(iHost_req, iHost_wr, full, empty);
    phys_elig  = req_eligible(iPhys_req, iPhys_wr, full, empty);
    grant_host = host_elig && (!phys_elig || (last_q == LAST_PHYS));
    grant_phys = phys_elig && !grant_host;
    op_wr      = grant_host ? iHost_wr : iPhys_wr;
    wdata      = grant_host ? iHost_data : iPhys_data;
    push_en    = !iReset && !iFlush && (grant_host || grant_phys) && op_wr;
    pop_en     = !iReset && !iFlush && (grant_host || grant_phys) && !op_wr;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    last_d   = last_q;
    if (push_en) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
      count_d  = count_q + CW'(1);
    end
    if (pop_en) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      count_d  = count_q - CW'(1);
    end
    if (grant_host) begin
      last_d = LAST_HOST;
    end else if (grant_phys) begin
      last_d = LAST_PHYS;
    end
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      last_q       <= LAST_PHYS;
      host_grant_q <= 1'b0;
      phys_grant_q <= 1'b0;
      read_valid_q <= 1'b0;
      fifo_ok_q    <= 1'b1;
    end else if (iFlush) begin
      // Flush keeps the arbitration history; only discarded data trips the sticky flag.
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      host_grant_q <= 1'b0;
      phys_grant_q <= 1'b0;
      read_valid_q <= 1'b0;
      if (count_q != '0) begin
        fifo_ok_q <= 1'b0;
      end
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      last_q       <= last_d;
      host_grant_q <= grant_host;
      phys_grant_q <= grant_phys;
      read_valid_q <= pop_en;
    end
  end

  data_fifo_mem #(
    .DATA_W (FIFO_data_size),
    .DEPTH  (FIFO_depth)
  ) u_mem (
    .clk_i   (iClock),
    .rst_i   (iReset),
    .we_i    (push_en),
    .waddr_i (wr_ptr_q),
    .wdata_i (wdata),
    .re_i    (pop_en),
    .raddr_i (rd_ptr_q),
    .rdata_o (oData_out)
  );

  assign oHost_grant = host_grant_q;
  assign oPhys_grant = phys_grant_q;
  assign oRead_valid = read_valid_q;
  assign oFull       = full;
  assign oEmpty      = empty;
  assign oCount      = count_q;
  assign oFIFO_ok    = fifo_ok_q;

endmodule

// File: tb/tb_data_fifo_arbiter.sv
// Scoreboard bench: a queue-based model predicts each cycle's outputs; a monitor compares.
module tb_data_fifo_arbiter;
  import data_pkg::*;

  localparam int W  = FIFO_DATA_SIZE_DEF;
  localparam int D  = FIFO_DEPTH_DEF;
  localparam int CW = $clog2(D) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1, flush = 1'b0;
  logic          h_req = 1'b0, h_wr = 1'b0, p_req = 1'b0, p_wr = 1'b0;
  logic [W-1:0]  h_data = '0, p_data = '0;
  logic          h_gnt, p_gnt, rd_vld, full, empty, ok;
  logic [W-1:0]  dout;
  logic [CW-1:0] cnt;

  always #5 clk = ~clk;

  data_fifo_arbiter dut (
    .iClock      (clk),
    .iReset      (rst),
    .iFlush      (flush),
    .iHost_req   (h_req),
    .iHost_wr    (h_wr),
    .iHost_data  (h_data),
    .iPhys_req   (p_req),
    .iPhys_wr    (p_wr),
    .iPhys_data  (p_data),
    .oHost_grant (h_gnt),
    .oPhys_grant (p_gnt),
    .oData_out   (dout),
    .oRead_valid (rd_vld),
    .oFull       (full),
    .oEmpty      (empty),
    .oCount      (cnt),
    .oFIFO_ok    (ok)
  );

  typedef struct packed {
    logic          hg;
    logic          pg;
    logic          rv;
    logic [W-1:0]  dout;
    logic [CW-1:0] cnt;
    logic          full;
    logic          empty;
    logic          ok;
  } exp_t;

  exp_t         expq[$];
  logic [W-1:0] rdq[$];
  logic [W-1:0] mq[$];
  bit           m_last_phys = 1'b1;
  bit           m_ok = 1'b1;
  logic [W-1:0] m_dout = '0;
  bit           done = 1'b0;
  int           checks = 0;
  int           errors = 0;

  // Drive one cycle of stimulus and predict the outputs after the next edge.
  task automatic step(input bit r, input bit fl,
                      input bit hr, input bit hw, input logic [W-1:0] hd,
                      input bit pr, input bit pw, input logic [W-1:0] pd);
    bit gh, gp, rv, he, pe;
    exp_t e;
    @(posedge clk); #2;
    rst = r; flush = fl;
    h_req = hr; h_wr = hw; h_data = hd;
    p_req = pr; p_wr = pw; p_data = pd;
    gh = 0; gp = 0; rv = 0;
    if (r) begin
      mq.delete();
      m_last_phys = 1'b1;
      m_ok = 1'b1;
      m_dout = '0;
    end else if (fl) begin
      if (mq.size() > 0) m_ok = 1'b0;
      mq.delete();
    end else begin
      he = hr && (hw ? (mq.size() < D) : (mq.size() > 0));
      pe = pr && (pw ? (mq.size() < D) : (mq.size() > 0));
      if (he && pe) begin
        gh = m_last_phys;
        gp = !m_last_phys;
      end else begin
        gh = he;
        gp = pe;
      end
      if (gh || gp) begin
        if (gh ? hw : pw) begin
          mq.push_back(gh ? hd : pd);
        end else begin
          m_dout = mq.pop_front();
          rdq.push_back(m_dout);
          rv = 1;
        end
        m_last_phys = gp;
      end
    end
    e.hg = gh; e.pg = gp; e.rv = rv; e.dout = m_dout;
    e.cnt = CW'(mq.size());
    e.full = (mq.size() == D);
    e.empty = (mq.size() == 0);
    e.ok = m_ok;
    expq.push_back(e);
  endtask

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("host_grant", W'(h_gnt), W'(e.hg));
        chk("phys_grant", W'(p_gnt), W'(e.pg));
        chk("read_valid", W'(rd_vld), W'(e.rv));
        chk("data_out",   dout,       e.dout);
        chk("count",      W'(cnt),    W'(e.cnt));
        chk("full",       W'(full),   W'(e.full));
        chk("empty",      W'(empty),  W'(e.empty));
        chk("fifo_ok",    W'(ok),     W'(e.ok));
        if (rd_vld === 1'b1) begin
          if (rdq.size() == 0) begin
            chk("unexpected_read", W'(1), W'(0));
          end else begin
            chk("read_order", dout, rdq.pop_front());
          end
        end
      end else if (done) begin
        chk("reads_outstanding", W'(rdq.size()), W'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
      end
    end
  end

  initial begin : timeout
    #2000000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin : stimulus
    step(1, 0, 0, 0, '0, 0, 0, '0);
    step(1, 0, 0, 0, '0, 0, 0, '0);
    // Fill to full from the host, then one held push.
    for (int i = 0; i < 9; i++) step(0, 0, 1, 1, 32'hA5A5_0001 + W'(i), 0, 0, '0);
    // Drain from phys, then one held pop.
    for (int i = 0; i < 9; i++) step(0, 0, 0, 0, '0, 1, 0, '0);
    // Steady state at count 4 with competing push and pop.
    for (int i = 0; i < 4; i++) step(0, 0, 1, 1, 32'h100 + W'(i), 0, 0, '0);
    for (int i = 0; i < 12; i++) step(0, 0, 1, 1, 32'h200 + W'(i), 1, 0, '0);
    // Same-cycle push and pop into an empty FIFO.
    step(1, 0, 0, 0, '0, 0, 0, '0);
    step(0, 0, 1, 1, 32'hBEEF_0001, 1, 0, '0);
    step(0, 0, 1, 1, 32'hBEEF_0002, 1, 0, '0);
    step(0, 0, 0, 0, '0, 0, 0, '0);
    // Pointer wrap.
    step(1, 0, 0, 0, '0, 0, 0, '0);
    for (int i = 0; i < 6; i++) step(0, 0, 1, 1, 32'h7000 + W'(i), 0, 0, '0);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, '0, 1, 0, '0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, '0, 1, 1, W'(32'h11 * (i + 1)));
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0, '0, 0, 0, '0);
    // Flush with data present, then recover through reset.
    step(1, 0, 0, 0, '0, 0, 0, '0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 1, 32'hF000 + W'(i), 0, 0, '0);
    step(0, 1, 1, 1, 32'hDEAD, 1, 0, '0);
    step(0, 0, 0, 0, '0, 0, 0, '0);
    step(1, 0, 0, 0, '0, 0, 0, '0);
    step(0, 0, 0, 0, '0, 0, 0, '0);
    // Randomized traffic with occasional flush and reset.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 39) == 0),
           $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, W'($urandom),
           $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, W'($urandom));
    end
    step(0, 0, 0, 0, '0, 0, 0, '0);
    repeat (3) @(posedge clk);
    done = 1'b1;
  end

endmodule
